// File: rtl/lstm_pkg.sv
// Shared LSTM definitions: default datapath geometry, input-fetch FSM states
// and a counter-width helper.
package lstm_pkg;

    localparam int LSTM_WIDTH          = 32;
    localparam int LSTM_NUM            = 68;
    localparam int LSTM_NUM_ITERATIONS = 8;
    localparam int LSTM_FRAC           = 24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } fetch_state_t;

    // Counter width for n states; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lstm_seq_counter.sv
// Feature/timestep position of the word currently presented to the LSTM cell.
// The feature index wraps at NUM-1 and carries into the step index.
module lstm_seq_counter
    import lstm_pkg::*;
#(
    parameter int NUM            = LSTM_NUM,
    parameter int NUM_ITERATIONS = LSTM_NUM_ITERATIONS,
    parameter int FW             = cnt_w(NUM),
    parameter int SW             = cnt_w(NUM_ITERATIONS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic          i_advance,
    output logic [SW-1:0] o_step,
    output logic          o_feat_last,
    output logic          o_seq_last
);

    localparam logic [FW-1:0] FEAT_MAX = FW'(NUM - 1);
    localparam logic [SW-1:0] STEP_MAX = SW'(NUM_ITERATIONS - 1);

    logic [FW-1:0] r_feature;
    logic [SW-1:0] r_step;

    logic w_feat_last;
    logic w_step_last;

    assign w_feat_last = (r_feature == FEAT_MAX);
    assign w_step_last = (r_step == STEP_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_feature <= '0;
            r_step    <= '0;
        end else if (i_clear) begin
            r_feature <= '0;
            r_step    <= '0;
        end else if (i_advance) begin
            if (w_feat_last) begin
                r_feature <= '0;
                r_step    <= w_step_last ? '0 : r_step + 1'b1;
            end else begin
                r_feature <= r_feature + 1'b1;
            end
        end
    end

    assign o_step      = r_step;
    assign o_feat_last = w_feat_last;
    assign o_seq_last  = w_feat_last & w_step_last;

endmodule

// File: rtl/input_x_fetch.sv
// Streams NUM*NUM_ITERATIONS input words from a combinational ROM to the LSTM
// cell over a valid/ready handshake. Option: INPUT_X_FETCH_BIAS_INJECT_EN.
module input_x_fetch
    import lstm_pkg::*;
#(
    parameter int WIDTH          = LSTM_WIDTH,
    parameter int NUM            = LSTM_NUM,
    parameter int NUM_ITERATIONS = LSTM_NUM_ITERATIONS,
    parameter int FRAC           = LSTM_FRAC
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic [WIDTH-1:0]                    mem_addr,
    input  logic signed [WIDTH-1:0]             mem_data,
    output logic signed [WIDTH-1:0]             x_data,
    output logic                                x_valid,
    input  logic                                x_ready,
    output logic                                x_last,
    output logic [cnt_w(NUM_ITERATIONS)-1:0]    x_step,
    output logic                                busy,
    output logic                                done
);

    localparam int SW = cnt_w(NUM_ITERATIONS);
    localparam logic [WIDTH-1:0]        LAST_ADDR = WIDTH'(NUM * NUM_ITERATIONS - 1);
    localparam logic signed [WIDTH-1:0] BIAS_WORD = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [WIDTH-1:0]        r_mem_addr;
    logic signed [WIDTH-1:0] r_x_data;
    logic                    r_x_valid;

    logic [WIDTH-1:0] w_addr_inc;
    logic             w_xfer;
    logic             w_clear;
    logic             w_advance;
    logic [SW-1:0]    w_step;
    logic             w_feat_last;
    logic             w_seq_last;
    logic             w_inject;

    assign w_xfer = r_x_valid & x_ready;

    // mem_addr runs one word ahead of x_data, so it saturates at the last address
    assign w_addr_inc = (r_mem_addr == LAST_ADDR) ? r_mem_addr : r_mem_addr + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_clear      = 1'b1;
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_state_next = ST_STREAM;
            end
            ST_STREAM: begin
                if (w_xfer) begin
                    if (w_seq_last) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_addr <= '0;
            r_x_data   <= '0;
            r_x_valid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mem_addr <= '0;
                    end
                end
                ST_LOAD: begin
                    r_x_data   <= mem_data;
                    r_x_valid  <= 1'b1;
                    r_mem_addr <= w_addr_inc;
                end
                ST_STREAM: begin
                    if (w_xfer) begin
                        if (w_seq_last) begin
                            r_x_valid <= 1'b0;
                        end else begin
                            r_x_data   <= mem_data;
                            r_mem_addr <= w_addr_inc;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    lstm_seq_counter #(
        .NUM            (NUM),
        .NUM_ITERATIONS (NUM_ITERATIONS),
        .SW             (SW)
    ) u_seq_counter (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_clear),
        .i_advance   (w_advance),
        .o_step      (w_step),
        .o_feat_last (w_feat_last),
        .o_seq_last  (w_seq_last)
    );

`ifdef INPUT_X_FETCH_BIAS_INJECT_EN
    // The bias slot is substituted at the output; the ROM is still addressed.
    assign w_inject = r_x_valid & w_feat_last;
`else
    assign w_inject = 1'b0;
`endif

    assign mem_addr = r_mem_addr;
    assign x_data   = w_inject ? BIAS_WORD : r_x_data;
    assign x_valid  = r_x_valid;
    assign x_last   = r_x_valid & w_feat_last;
    assign x_step   = w_step;
    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_input_x_fetch.sv
// Scoreboard bench for input_x_fetch: ROM returns data=addr, expected words are
// queued from the sequence definition and popped by a negedge monitor.
module tb_input_x_fetch;

    localparam int W     = 32;
    localparam int N     = 68;
    localparam int NI    = 8;
    localparam int FR    = 24;
    localparam int SW    = (NI > 1) ? $clog2(NI) : 1;
    localparam int TOTAL = N * NI;
    localparam int BUDGET = 6 * TOTAL + 200;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [W-1:0]         mem_addr;
    logic signed [W-1:0]  mem_data;
    logic signed [W-1:0]  x_data;
    logic                 x_valid;
    logic                 x_ready;
    logic                 x_last;
    logic [SW-1:0]        x_step;
    logic                 busy;
    logic                 done;

    typedef struct {
        logic [W-1:0] data;
        int           step;
        bit           last;
        bit           fin;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_xfer = 0;
    bit   done_pending = 0;

    bit            prev_stall = 0;
    logic [W-1:0]  prv_data;
    logic          prv_last;
    logic [SW-1:0] prv_step;
    logic [W-1:0]  prv_addr;

    input_x_fetch #(
        .WIDTH          (W),
        .NUM            (N),
        .NUM_ITERATIONS (NI),
        .FRAC           (FR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .x_data   (x_data),
        .x_valid  (x_valid),
        .x_ready  (x_ready),
        .x_last   (x_last),
        .x_step   (x_step),
        .busy     (busy),
        .done     (done)
    );

    assign mem_data = mem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic build_expected();
        exp_t e;
        exp_q.delete();
        for (int s = 0; s < NI; s++) begin
            for (int f = 0; f < N; f++) begin
                e.data = 32'(s * N + f);
`ifdef INPUT_X_FETCH_BIAS_INJECT_EN
                if (f == N - 1) e.data = 32'd1 << FR;
`endif
                e.step = s;
                e.last = (f == N - 1);
                e.fin  = (s == NI - 1) && (f == N - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(x_valid), 64'd1);
                check("stall_data", 64'($unsigned(x_data)), 64'(prv_data));
                check("stall_last", 64'(x_last), 64'(prv_last));
                check("stall_step", 64'(x_step), 64'(prv_step));
                check("stall_addr", 64'(mem_addr), 64'(prv_addr));
            end
            if (busy) check("addr_bound", 64'(mem_addr <= W'(TOTAL - 1)), 64'd1);
            if (done) begin
                check("done_expected", 64'(done_pending), 64'd1);
                done_pending = 0;
            end
            if (x_valid && x_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_word: got %0h expected no transfer", x_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("word_data", 64'($unsigned(x_data)), 64'(e.data));
                    check("word_last", 64'(x_last), 64'(e.last));
                    check("word_step", 64'(x_step), 64'(e.step));
                    n_xfer++;
                    if (e.fin) done_pending = 1;
                end
            end
            prev_stall = x_valid && !x_ready;
            prv_data   = $unsigned(x_data);
            prv_last   = x_last;
            prv_step   = x_step;
            prv_addr   = mem_addr;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"},  64'(mem_addr), 64'd0);
        check({tag, "_data"},  64'($unsigned(x_data)), 64'd0);
        check({tag, "_valid"}, 64'(x_valid), 64'd0);
        check({tag, "_last"},  64'(x_last), 64'd0);
        check({tag, "_step"},  64'(x_step), 64'd0);
        check({tag, "_busy"},  64'(busy), 64'd0);
        check({tag, "_done"},  64'(done), 64'd0);
    endtask

    // mode: 0 = always ready, 1 = ready 1010..., 2 = random ready
    task automatic run_seq(input int mode, input bit extra_starts, input bit abort);
        bit got_done;
        got_done = 0;
        build_expected();
        n_xfer = 0;
        done_pending = 0;
        x_ready = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("load_valid_low", 64'(x_valid), 64'd0);
        check("load_busy", 64'(busy), 64'd1);
        check("load_addr0", 64'(mem_addr), 64'd0);
        @(posedge clk); #1;
        check("first_valid", 64'(x_valid), 64'd1);
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            if (done) begin
                got_done = 1;
                break;
            end
            if (abort && n_xfer >= 100) break;
            start = extra_starts && (cyc == 5 || cyc == 50);
            case (mode)
                1:       x_ready = (cyc % 2 == 0);
                2:       x_ready = 1'($urandom_range(0, 1));
                default: x_ready = 1'b1;
            endcase
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (abort) begin
            check("abort_reached", 64'(n_xfer >= 100), 64'd1);
            rst = 1'b0;
            #1;
            check_all_zero("mid_reset");
            exp_q.delete();
            done_pending = 0;
            @(posedge clk); #1 rst = 1'b1;
            repeat (5) @(posedge clk);
            #1;
            check("no_resume_busy", 64'(busy), 64'd0);
            check("no_resume_valid", 64'(x_valid), 64'd0);
            check("no_resume_addr", 64'(mem_addr), 64'd0);
        end else begin
            check("seq_done_seen", 64'(got_done), 64'd1);
            check("queue_drained", 64'(exp_q.size()), 64'd0);
            start = extra_starts;
            @(posedge clk); #1 start = 1'b0;
            check("done_one_cycle", 64'(done), 64'd0);
            check("idle_after_done", 64'(busy), 64'd0);
            check("idle_addr_hold", 64'(mem_addr), 64'(TOTAL - 1));
            repeat (3) @(posedge clk);
            #1;
            check("start_on_done_ignored", 64'(busy), 64'd0);
            check("idle_valid_low", 64'(x_valid), 64'd0);
        end
    endtask

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        x_ready = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("idle_without_start", 64'(busy), 64'd0);

        run_seq(0, 1'b1, 1'b0);
        run_seq(1, 1'b0, 1'b0);
        run_seq(2, 1'b0, 1'b0);
        run_seq(0, 1'b0, 1'b1);
        run_seq(2, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
